// File: rtl/vcbn_cled.sv
// vcbn_cled: modulo up/down counter with load, terminal count and cascade enable.
// Define VCBN_CLED_PRESCALE_EN to step once per PRESCALE ce pulses.
module vcbn_cled #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ce,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             CEO
);
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
  logic [WIDTH-1:0] q_q, q_d;
  logic             en;
`ifdef VCBN_CLED_PRESCALE_EN
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
  logic [PW-1:0] p_q, p_d;
  always_comb begin
    en  = ce & (p_q == PMAX);
    p_d = load ? '0 : ce ? (p_q == PMAX ? '0 : p_q + 1'b1) : p_q;
  end
  always_ff @(posedge clk or posedge clr)
    if (clr) p_q <= '0;
    else     p_q <= p_d;
`else
  assign en = ce;
`endif
  // Width-extended compare so the clamp is inert when MODULUS == 2**WIDTH.
  always_comb begin
    q_d = load ? (({1'b0, d} >= (WIDTH+1)'(MODULUS)) ? MAX : d)
        : en   ? (up ? (q_q == MAX ? '0 : q_q + 1'b1) : (q_q == '0 ? MAX : q_q - 1'b1))
        : q_q;
  end
  always_ff @(posedge clk or posedge clr)
    if (clr) q_q <= '0;
    else     q_q <= q_d;
  assign Q   = q_q;
  assign TC  = up ? (q_q == MAX) : (q_q == '0);
  assign CEO = TC & en;
endmodule

// File: tb/tb_vcbn_cled.sv
// tb_vcbn_cled: scoreboard bench for vcbn_cled with WIDTH=4, MODULUS=10.
module tb_vcbn_cled;
  logic       clk = 0, clr = 1, ce = 0, up = 1, load = 0;
  logic [3:0] d = 0, Q;
  logic       TC, CEO;
  int         total = 0, bad = 0;
  int         m = 0, p = 0;
  int         exp_q[$];
  vcbn_cled #(.WIDTH(4), .MODULUS(10), .PRESCALE(4)) dut (
    .clk(clk), .clr(clr), .ce(ce), .up(up), .load(load), .d(d), .Q(Q), .TC(TC), .CEO(CEO)
  );
  always #10 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(input logic c, input logic u, input logic l, input logic [3:0] dv);
    int e, t;
    ce = c; up = u; load = l; d = dv;
    #1;
`ifdef VCBN_CLED_PRESCALE_EN
    e = (c && p == 3) ? 1 : 0;
`else
    e = c ? 1 : 0;
`endif
    t = (u && m == 9) || (!u && m == 0) ? 1 : 0;
    chk("tc", int'(TC), t);
    chk("ceo", int'(CEO), t & e);
    if (l) m = dv > 9 ? 9 : int'(dv);
    else if (e == 1) m = u ? (m + 1) % 10 : (m + 9) % 10;
`ifdef VCBN_CLED_PRESCALE_EN
    if (l) p = 0;
    else if (c) p = (p + 1) % 4;
`endif
    exp_q.push_back(m);
    @(posedge clk); #1;
    chk("q", int'(Q), exp_q.pop_front());
    @(negedge clk);
  endtask
  initial begin
    #5;
    chk("rst_q_async", int'(Q), 0);
    up = 0; ce = 1; load = 1; d = 7; #1;
    chk("rst_tc_down", int'(TC), 1);
    up = 1; #1;
    chk("rst_tc_up", int'(TC), 0);
    @(posedge clk); #1;
    chk("rst_hold", int'(Q), 0);
    @(negedge clk);
    clr = 0; load = 0; ce = 0;
    for (int i = 0; i < 12; i++) step(1, 1, 0, 0);
    step(0, 1, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    step(0, 1, 1, 7);
    ce = 1; up = 1;
    #5 clr = 1;
    #1 chk("clr_mid", int'(Q), 0);
    @(posedge clk); #1;
    chk("clr_held", int'(Q), 0);
    #4 clr = 0;
    m = 0; p = 0;
    @(negedge clk);
    step(1, 1, 1, 5);
    step(1, 1, 1, 13);
    step(0, 0, 1, 3);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(1, 0, 1, 15);
    step(1, 1, 0, 0);
    step(1, 1, 1, 4);
    for (int i = 0; i < 4; i++) step(1, (i % 2) == 0, 0, 0);
    step(1, 1, 1, 0);
    for (int i = 0; i < 16; i++) step(1, 1, 0, 0);
    step(1, 1, 1, 2);
    for (int i = 0; i < 6; i++) step(1, 1, 0, 0);
    for (int i = 0; i < 60; i++)
      step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7) == 0,
           4'($urandom_range(0, 15)));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vcbn_cled.md
VCBN_CLED -- requirements
Module: vcbn_cled

Interface
REQ-001 SHALL have parameter WIDTH, default 4, counter width in bits.
REQ-002 SHALL have parameter MODULUS, default 16, count range 0..MODULUS-1; legal 2 <= MODULUS <= 2**WIDTH.
REQ-003 SHALL have parameter PRESCALE, default 4, ce pulses per count step; legal >= 1; used only per REQ-028.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port clr  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port ce  input  1  clock enable, sampled on rising clk.
REQ-007 SHALL have port up  input  1  direction: 1 = count up, 0 = count down.
REQ-008 SHALL have port load  input  1  synchronous parallel load strobe.
REQ-009 SHALL have port d  input  WIDTH  parallel load value.
REQ-010 SHALL have port Q  output  WIDTH  registered count value.
REQ-011 SHALL have port TC  output  1  terminal count, combinational from Q and up.
REQ-012 SHALL have port CEO  output  1  cascade enable out, combinational.

Function
REQ-013 SHALL define internal step enable en (ce or prescaler strobe, REQ-028/029).
REQ-014 SHALL give priority per rising edge: clr > load > en > hold.
REQ-015 SHALL on load=1 set Q <= d next edge, regardless of ce, up or en.
REQ-016 SHALL on load=1 with d >= MODULUS set Q <= MODULUS-1 (saturating clamp).
REQ-017 SHALL on en=1, up=1, load=0 set Q <= Q+1, wrapping MODULUS-1 -> 0.
REQ-018 SHALL on en=1, up=0, load=0 set Q <= Q-1, wrapping 0 -> MODULUS-1.
REQ-019 SHALL hold Q when en=0 and load=0.
REQ-020 SHALL drive TC=1 iff (up=1 and Q==MODULUS-1) or (up=0 and Q==0); independent of ce.
REQ-021 SHALL drive CEO = TC & en, one-cycle-wide when en is a one-cycle pulse.
REQ-022 SHALL respond to direction change on the same edge en is sampled; no pipeline latency.
REQ-023 SHALL never let Q leave 0..MODULUS-1 under any input sequence.
REQ-024 SHALL, for MODULUS == 2**WIDTH, behave as plain binary wrap counter.

Reset
REQ-025 SHALL on clr=1 immediately (no clk needed) force Q=0 and prescaler count=0.
REQ-026 SHALL hold reset state while clr=1, ignoring ce, load, up, d.
REQ-027 SHALL resume counting from 0 on first en after clr deasserts; TC/CEO follow REQ-020/021 (TC=1 during reset iff up=0).

Configuration
REQ-028 SHALL, with macro VCBN_CLED_PRESCALE_EN defined, include a prescaler p (0..PRESCALE-1) incrementing on each ce=1 edge, wrapping at PRESCALE-1; en = ce & (p==PRESCALE-1); load=1 also resets p to 0.
REQ-029 SHALL, without VCBN_CLED_PRESCALE_EN, omit prescaler logic entirely; en = ce; PRESCALE ignored.

Verification (WIDTH=4, MODULUS=10, clk period 20 ns, macro undefined unless stated)
REQ-030 SHALL cover: clr pulse 10 ns mid-cycle at Q=7 -> Q=0 before next edge, stays 0 while clr=1.
REQ-031 SHALL cover: ce=1, up=1 from Q=0 for 12 edges -> Q 1..9,0,1,2; TC=1 and CEO=1 only while Q=9.
REQ-032 SHALL cover: ce=1, up=0 from Q=0 -> Q 9,8,7; TC=1 at Q=0 only; CEO=1 in that cycle.
REQ-033 SHALL cover: load=1, d=5 with ce=1 -> Q=5 (load wins); load d=13 -> Q=9; load with ce=0 -> loads.
REQ-034 SHALL cover: ce held 1 with up toggling each cycle from Q=4 -> Q 5,4,5,4; Q never exceeds 9.
REQ-035 SHALL cover, macro defined, PRESCALE=4: ce=1 continuous 16 edges -> Q advances 0->4, one step per 4 edges; CEO pulses single-cycle; load mid-run restarts 4-edge spacing.
